// File: rtl/id_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_pipe
// Brief    : Instruction-decode stage: register file, decode, ID/EX register,
//            load-use hazard bubble and RUN/DRAIN/HALTED halt sequencer.
//            Define ID_BYPASS_EN to forward same-cycle writeback to reads.
// Revision : 1.0 - initial release
// ============================================================================
module id_pipe #(
   parameter int DATA_W    = 16,
   parameter int NREG      = 16,
   parameter int DRAIN_CYC = 3,
   localparam int AW       = $clog2(NREG)
) (
   input  logic              i_clk,
   input  logic              i_nRst,
   input  logic [15:0]       i_instr,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_stall,
   input  logic              i_flush,
   input  logic              i_wrEn,
   input  logic [AW-1:0]     i_wrReg,
   input  logic [DATA_W-1:0] i_wrData,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_port0,
   output logic [DATA_W-1:0] o_port1,
   output logic [AW-1:0]     o_wrReg,
   output logic [AW-1:0]     o_rdReg1,
   output logic [AW-1:0]     o_rdReg2,
   output logic              o_wrRegEn,
   output logic              o_memRd,
   output logic              o_memWr,
   output logic              o_mem2reg,
   output logic              o_aluSrc,
   output logic              o_sawBr,
   output logic              o_hlt,
   output logic [3:0]        o_aluOp,
   output logic [3:0]        o_imm,
   output logic              o_halted
);

   localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;
   localparam logic [CW-1:0] c_CNT_LAST = CW'(DRAIN_CYC - 1);

   typedef enum logic [1:0] {
      c_RUN    = 2'd0,
      c_DRAIN  = 2'd1,
      c_HALTED = 2'd2
   } state_t;

   typedef struct packed {
      logic              vld;
      logic [DATA_W-1:0] port0;
      logic [DATA_W-1:0] port1;
      logic [AW-1:0]     wrReg;
      logic [AW-1:0]     rdReg1;
      logic [AW-1:0]     rdReg2;
      logic              wrRegEn;
      logic              memRd;
      logic              memWr;
      logic              aluSrc;
      logic              sawBr;
      logic              hlt;
      logic [3:0]        aluOp;
      logic [3:0]        imm;
   } idex_t;

   logic [DATA_W-1:0] r_regs [NREG];
   idex_t             r_idex;
   state_t            r_state;
   state_t            w_stateNxt;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cntNxt;

   logic [3:0]        w_op;
   logic [AW-1:0]     w_rd;
   logic [AW-1:0]     w_rs;
   logic [AW-1:0]     w_rt;
   logic [AW-1:0]     w_rdA1;
   logic [AW-1:0]     w_rdA2;
   logic [AW-1:0]     w_wrReg;
   logic              w_wrRegEn;
   logic              w_memRd;
   logic              w_memWr;
   logic              w_aluSrc;
   logic              w_sawBr;
   logic              w_hlt;
   logic [3:0]        w_aluOp;
   logic [DATA_W-1:0] w_port0;
   logic [DATA_W-1:0] w_port1;
   idex_t             w_dec;
   logic              w_hazard;
   logic              w_ready;
   logic              w_capture;
   logic              w_advance;

   assign w_op = i_instr[15:12];
   assign w_rd = i_instr[8 +: AW];
   assign w_rs = i_instr[4 +: AW];
   assign w_rt = i_instr[0 +: AW];

   // Unused read addresses stay 0 so they read zero and never match a hazard
   always_comb begin
      w_rdA1    = '0;
      w_rdA2    = '0;
      w_wrReg   = '0;
      w_wrRegEn = 1'b0;
      w_memRd   = 1'b0;
      w_memWr   = 1'b0;
      w_aluSrc  = 1'b0;
      w_sawBr   = 1'b0;
      w_hlt     = 1'b0;
      w_aluOp   = 4'd0;
      casez (w_op)
         4'b0???: begin
            w_aluOp   = w_op;
            w_rdA1    = w_rs;
            w_rdA2    = w_rt;
            w_wrReg   = w_rd;
            w_wrRegEn = 1'b1;
         end
         4'b1000: begin
            w_rdA1    = w_rs;
            w_wrReg   = w_rd;
            w_wrRegEn = 1'b1;
            w_memRd   = 1'b1;
            w_aluSrc  = 1'b1;
         end
         4'b1001: begin
            w_rdA1   = w_rs;
            w_rdA2   = w_rd;
            w_memWr  = 1'b1;
            w_aluSrc = 1'b1;
         end
         4'b1100: begin
            w_rdA1  = w_rs;
            w_sawBr = 1'b1;
         end
         4'b1111: w_hlt = 1'b1;
         default: ;
      endcase
   end

`ifdef ID_BYPASS_EN
   logic w_byp0;
   logic w_byp1;
   assign w_byp0  = i_wrEn && (i_wrReg != '0) && (i_wrReg == w_rdA1);
   assign w_byp1  = i_wrEn && (i_wrReg != '0) && (i_wrReg == w_rdA2);
   assign w_port0 = w_byp0 ? i_wrData : r_regs[w_rdA1];
   assign w_port1 = w_byp1 ? i_wrData : r_regs[w_rdA2];
`else
   assign w_port0 = r_regs[w_rdA1];
   assign w_port1 = r_regs[w_rdA2];
`endif

   assign w_dec = '{vld: 1'b1, port0: w_port0, port1: w_port1,
                    wrReg: w_wrReg, rdReg1: w_rdA1, rdReg2: w_rdA2,
                    wrRegEn: w_wrRegEn, memRd: w_memRd, memWr: w_memWr,
                    aluSrc: w_aluSrc, sawBr: w_sawBr, hlt: w_hlt,
                    aluOp: w_aluOp, imm: i_instr[3:0]};

   assign w_hazard  = i_valid && r_idex.vld && r_idex.memRd && (r_idex.wrReg != '0) &&
                      ((r_idex.wrReg == w_rdA1) || (r_idex.wrReg == w_rdA2));
   assign w_ready   = (r_state == c_RUN) && !w_hazard && !(i_stall && !i_flush);
   assign w_capture = i_valid && w_ready && !i_flush;
   // A drain cycle only counts when a bubble actually enters ID/EX
   assign w_advance = i_flush || !i_stall;

   always_ff @(posedge i_clk) begin
      if (!i_nRst) begin
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else if (i_wrEn && (i_wrReg != '0)) begin
         r_regs[i_wrReg] <= i_wrData;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_nRst)        r_idex <= '0;
      else if (i_flush)   r_idex <= '0;
      else if (i_stall)   r_idex <= r_idex;
      else if (w_capture) r_idex <= w_dec;
      else                r_idex <= '0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_nRst) begin
         r_state <= c_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_stateNxt;
         r_cnt   <= w_cntNxt;
      end
   end

   always_comb begin
      w_stateNxt = r_state;
      w_cntNxt   = r_cnt;
      case (r_state)
         c_RUN: begin
            if (w_capture && w_hlt) begin
               w_stateNxt = c_DRAIN;
               w_cntNxt   = '0;
            end
         end
         c_DRAIN: begin
            if (w_advance) begin
               if (r_cnt == c_CNT_LAST) begin
                  w_stateNxt = c_HALTED;
                  w_cntNxt   = '0;
               end else begin
                  w_cntNxt = r_cnt + CW'(1);
               end
            end
         end
         c_HALTED: ;
         default: begin
            w_stateNxt = c_RUN;
            w_cntNxt   = '0;
         end
      endcase
   end

   assign o_ready   = w_ready;
   assign o_valid   = r_idex.vld;
   assign o_port0   = r_idex.port0;
   assign o_port1   = r_idex.port1;
   assign o_wrReg   = r_idex.wrReg;
   assign o_rdReg1  = r_idex.rdReg1;
   assign o_rdReg2  = r_idex.rdReg2;
   assign o_wrRegEn = r_idex.wrRegEn;
   assign o_memRd   = r_idex.memRd;
   assign o_memWr   = r_idex.memWr;
   assign o_mem2reg = r_idex.memRd;
   assign o_aluSrc  = r_idex.aluSrc;
   assign o_sawBr   = r_idex.sawBr;
   assign o_hlt     = r_idex.hlt;
   assign o_aluOp   = r_idex.aluOp;
   assign o_imm     = r_idex.imm;
   assign o_halted  = (r_state == c_HALTED);

endmodule
`default_nettype wire

// File: doc/id_pipe.md
ID_PIPE -- requirements
Module: id_pipe

Interface
REQ-001 Parameter DATA_W, 16, register and port data width.
REQ-002 Parameter NREG, 16, register count; power of two; address width AW = log2(NREG), 4 by default.
REQ-003 Parameter DRAIN_CYC, 3, cycles spent in DRAIN after a halt before HALTED.
REQ-004 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_nRst  in  1  reset, synchronous, active-low.
REQ-006 i_instr  in  16  instruction word; fields op=[15:12], rd=[11:8], rs=[7:4], rt/imm=[3:0].
REQ-007 i_valid  in  1  i_instr is valid this cycle.
REQ-008 o_ready  out  1  stage accepts i_instr this cycle.
REQ-009 i_stall  in  1  downstream stall; hold ID/EX register.
REQ-010 i_flush  in  1  discard the instruction being captured this cycle.
REQ-011 i_wrEn, i_wrReg, i_wrData  in  1/AW/DATA_W  writeback port.
REQ-012 o_valid  out  1  ID/EX register holds a live instruction.
REQ-013 o_port0, o_port1  out  DATA_W  registered operand values.
REQ-014 o_wrReg, o_rdReg1, o_rdReg2  out  AW  registered register addresses.
REQ-015 o_wrRegEn, o_memRd, o_memWr, o_mem2reg, o_aluSrc, o_sawBr, o_hlt  out  1  registered controls.
REQ-016 o_aluOp, o_imm  out  4  registered ALU op and zero-extended immediate.
REQ-017 o_halted  out  1  FSM is in HALTED.

Function
REQ-018 Decode: op 0000-0111 ALU (aluOp=op, read rs/rt, write rd); 1000 LW (read rs, write rd, memRd, aluSrc); 1001 SW (read rs and rd, memWr, aluSrc); 1100 BR (read rs, sawBr); 1111 HLT; others NOP (all controls 0).
REQ-019 o_mem2reg SHALL equal o_memRd.
REQ-020 Register file: NREG x DATA_W, two combinational read ports, one write port; register 0 reads 0 and ignores writes.
REQ-021 Latency: instruction accepted (i_valid & o_ready) at edge N appears on ID/EX outputs with o_valid=1 after edge N.
REQ-022 Load-use hazard: o_valid & o_memRd & o_wrReg!=0 & o_wrReg equals a register read by i_instr -> o_ready=0, bubble (o_valid=0) loaded next edge unless i_stall.
REQ-023 Priority per edge: i_nRst low > i_flush (load bubble) > i_stall (hold all ID/EX outputs) > hazard bubble > capture.
REQ-024 o_ready=0 whenever i_stall=1 and i_flush=0, during hazard, or FSM not RUN.
REQ-025 FSM RUN -> DRAIN on capturing HLT (o_hlt=1 with it); DRAIN counts DRAIN_CYC edges loading bubbles -> HALTED; HALTED persists until reset.
REQ-026 i_flush in DRAIN SHALL NOT return to RUN; flush of the captured HLT itself cancels it (stay RUN).
REQ-027 Writeback remains functional in all FSM states.

Reset
REQ-028 On i_nRst low at an edge: FSM=RUN, drain counter=0, all ID/EX outputs and o_valid=0, all registers=0, o_halted=0.
REQ-029 Reset mid-DRAIN or mid-stall SHALL discard all in-flight state.

Configuration
REQ-030 Macro ID_BYPASS_EN defined: read of register equal to i_wrReg with i_wrEn=1 (non-zero) returns i_wrData same cycle.
REQ-031 Macro ID_BYPASS_EN undefined: that read returns the pre-write value; new value visible next cycle.

Verification
REQ-032 Write R3=0x1234, then ADD rd=5,rs=3,rt=3 -> next cycle o_port0=o_port1=0x1234, o_aluOp=0, o_wrReg=5.
REQ-033 Same-cycle write R4=0xBEEF and read rs=4 -> o_port0=0xBEEF with ID_BYPASS_EN, old 0x0000 without.
REQ-034 LW rd=2 followed by ADD rs=2 -> o_ready=0 one cycle, one o_valid=0 bubble, then ADD captured.
REQ-035 i_stall=1 for 3 cycles -> ID/EX outputs unchanged; i_flush with i_stall -> o_valid=0.
REQ-036 HLT with DRAIN_CYC=3 -> o_hlt=1 one cycle, 3 bubbles, o_halted=1 at 4th edge; reset returns to RUN, o_halted=0.
REQ-037 Write to R0=0xFFFF then read R0 -> 0x0000.
